// File: rtl/config_arb_pkg.sv
// Shared types and constants for the configuration source arbiter.
package config_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GUARD   = 2'd1,
        S_GRANTED = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int              WC_W   = 16;
    localparam logic [WC_W-1:0] WC_MAX = '1;

endpackage

// File: rtl/config_source_arbiter_if.sv
// Bundle of source-side and ConfigFSM-side signals of the arbiter.
interface config_source_arbiter_if
    import config_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 3,
    parameter int DATA_WIDTH  = 32
) ();
    localparam int IDX_W = $clog2(NUM_SOURCES);

    logic [NUM_SOURCES-1:0]            SourceActive;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] SourceWriteData;
    logic [NUM_SOURCES-1:0]            SourceWriteStrobe;
    logic [DATA_WIDTH-1:0]             ConfigWriteData;
    logic                              ConfigWriteStrobe;
    logic                              FSM_Reset;
    logic                              ComActive;
    logic [IDX_W-1:0]                  ActiveSource;
    logic [WC_W-1:0]                   WordCount;
    logic [NUM_SOURCES-1:0]            DroppedStrobe;
    logic                              TimeoutFlag;

    // Arbiter side
    modport slave (
        input  SourceActive, SourceWriteData, SourceWriteStrobe,
        output ConfigWriteData, ConfigWriteStrobe, FSM_Reset, ComActive,
        output ActiveSource, WordCount, DroppedStrobe, TimeoutFlag
    );

    // Source / environment side
    modport master (
        output SourceActive, SourceWriteData, SourceWriteStrobe,
        input  ConfigWriteData, ConfigWriteStrobe, FSM_Reset, ComActive,
        input  ActiveSource, WordCount, DroppedStrobe, TimeoutFlag
    );

endinterface

// File: rtl/config_arb_picker.sv
// Combinational grant selector: fixed priority or round robin after ptr_i.
module config_arb_picker
    import config_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 3,
    parameter int IDX_W       = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] req_i,
    input  logic [NUM_SOURCES-1:0] mask_i,
    input  logic [IDX_W-1:0]       ptr_i,
    input  logic                   mode_i,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   vld_o
);
    logic [NUM_SOURCES-1:0] elig;

    assign elig = req_i & ~mask_i;

    // Scan from the lowest-priority candidate upward so the last hit wins
    always_comb begin
        int j;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        if (mode_i) begin
            for (int k = NUM_SOURCES; k >= 1; k--) begin
                j = (int'(ptr_i) + k) % NUM_SOURCES;
                if (elig[j]) begin
                    idx_o = IDX_W'(j);
                    vld_o = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    idx_o = IDX_W'(i);
                    vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/config_source_arbiter.sv
// Grants one configuration source at a time to the ConfigFSM, with a
// resynchronisation guard on every new grant and an idle timeout.
module config_source_arbiter
    import config_arb_pkg::*;
#(
    parameter int NUM_SOURCES  = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ARB_MODE     = 0,
    parameter int GUARD_CYCLES = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input logic                    CLK,
    input logic                    resetn,
    config_source_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SOURCES);
    localparam int TMO_W = $clog2(IDLE_TIMEOUT);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       src_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [3:0]             guard_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [NUM_SOURCES-1:0] mask_q;
    logic [NUM_SOURCES-1:0] mask_d;
    logic [NUM_SOURCES-1:0] drop_q;
    logic [NUM_SOURCES-1:0] gnt_sel;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  gnt_word;
    logic [WC_W-1:0]        wcnt_q;
    logic                   wstb_q;
    logic                   tflag_q;
    logic                   gnt_act;
    logic                   fwd;
    logic                   tmo_hit;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;

    config_arb_picker #(
        .NUM_SOURCES (NUM_SOURCES),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i  (bus.SourceActive),
        .mask_i (mask_q),
        .ptr_i  (ptr_q),
        .mode_i (ARB_MODE != ARB_FIXED),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // Granted-source view of this cycle: forward decision, timeout, mask update
    always_comb begin
        gnt_sel = '0;
        if (state_q == S_GRANTED) gnt_sel[src_q] = 1'b1;
        gnt_act  = bus.SourceActive[src_q];
        gnt_word = bus.SourceWriteData[int'(src_q)*DATA_WIDTH +: DATA_WIDTH];
        fwd      = |(bus.SourceWriteStrobe & gnt_sel);
        tmo_hit  = (state_q == S_GRANTED) && gnt_act && !fwd &&
                   (tmo_q == TMO_W'(IDLE_TIMEOUT - 1));
        mask_d   = mask_q & bus.SourceActive;
        if (tmo_hit) mask_d[src_q] = 1'b1;
    end

    // Session FSM with forwarding, counters and sticky flags
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            ptr_q   <= IDX_W'(NUM_SOURCES - 1);
            guard_q <= '0;
            tmo_q   <= '0;
            mask_q  <= '0;
            drop_q  <= '0;
            wdata_q <= '0;
            wstb_q  <= 1'b0;
            wcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            wstb_q <= 1'b0;
            mask_q <= mask_d;
            drop_q <= drop_q | (bus.SourceWriteStrobe & ~gnt_sel);
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_q <= S_GUARD;
                        src_q   <= pick_idx;
                        ptr_q   <= pick_idx;
                        guard_q <= '0;
                        wcnt_q  <= '0;
                    end
                end
                S_GUARD: begin
                    if (!gnt_act) begin
                        state_q <= S_IDLE;
                        src_q   <= '0;
                    end else if (guard_q == 4'(GUARD_CYCLES - 1)) begin
                        state_q <= S_GRANTED;
                        tmo_q   <= '0;
                    end else begin
                        guard_q <= guard_q + 4'd1;
                    end
                end
                S_GRANTED: begin
                    if (fwd) begin
                        wstb_q  <= 1'b1;
                        wdata_q <= gnt_word;
                        tmo_q   <= '0;
                        if (wcnt_q != WC_MAX) wcnt_q <= wcnt_q + 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (!gnt_act || tmo_hit) begin
                        state_q <= S_IDLE;
                        src_q   <= '0;
                    end
                    if (tmo_hit) tflag_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    src_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ConfigWriteData   = wdata_q;
    assign bus.ConfigWriteStrobe = wstb_q;
    assign bus.FSM_Reset         = (state_q == S_GUARD);
    assign bus.ComActive         = (state_q != S_IDLE);
    assign bus.ActiveSource      = src_q;
    assign bus.WordCount         = wcnt_q;
    assign bus.DroppedStrobe     = drop_q;
    assign bus.TimeoutFlag       = tflag_q;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Bench for config_source_arbiter: a fixed-priority and a round-robin
// instance share one stimulus; directed scenarios plus a random run
// checked against a session-level reference model.
module tb_config_source_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int G  = 4;
    localparam int TO = 8;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    act;
    logic [N-1:0]    stb;
    logic [N*DW-1:0] data;

    int total = 0;
    int bad   = 0;

    config_source_arbiter_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW)) ifa ();
    config_source_arbiter_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW)) ifb ();

    assign ifa.SourceActive      = act;
    assign ifa.SourceWriteStrobe = stb;
    assign ifa.SourceWriteData   = data;
    assign ifb.SourceActive      = act;
    assign ifb.SourceWriteStrobe = stb;
    assign ifb.SourceWriteData   = data;

    config_source_arbiter #(
        .NUM_SOURCES(N), .DATA_WIDTH(DW), .ARB_MODE(0),
        .GUARD_CYCLES(G), .IDLE_TIMEOUT(TO)
    ) dut_fp (.CLK(clk), .resetn(resetn), .bus(ifa));

    config_source_arbiter #(
        .NUM_SOURCES(N), .DATA_WIDTH(DW), .ARB_MODE(1),
        .GUARD_CYCLES(G), .IDLE_TIMEOUT(TO)
    ) dut_rr (.CLK(clk), .resetn(resetn), .bus(ifb));

    logic [56:0] obs [2];
    assign obs[0] = {ifa.ComActive, ifa.FSM_Reset, ifa.ActiveSource, ifa.ConfigWriteStrobe,
                     ifa.ConfigWriteData, ifa.WordCount, ifa.DroppedStrobe, ifa.TimeoutFlag};
    assign obs[1] = {ifb.ComActive, ifb.FSM_Reset, ifb.ActiveSource, ifb.ConfigWriteStrobe,
                     ifb.ConfigWriteData, ifb.WordCount, ifb.DroppedStrobe, ifb.TimeoutFlag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one set per instance (0 = fixed, 1 = round robin)
    logic        mb    [2];
    int          ms    [2];
    int          mage  [2];
    int          msil  [2];
    int          mlast [2];
    logic [2:0]  mmask [2];
    logic [2:0]  mdrop [2];
    logic        mtf   [2];
    logic        mcws  [2];
    logic [15:0] mwc   [2];
    logic [31:0] mcwd  [2];

    task automatic model_init();
        for (int m = 0; m < 2; m++) begin
            mb[m] = 1'b0; ms[m] = 0; mage[m] = 0; msil[m] = 0; mlast[m] = N - 1;
            mmask[m] = '0; mdrop[m] = '0; mtf[m] = 1'b0; mcws[m] = 1'b0;
            mwc[m] = '0; mcwd[m] = '0;
        end
    endtask

    // Advance model m by one clock using the inputs currently applied
    task automatic model_step(input int m);
        logic       ing;
        logic       fwdm;
        logic [2:0] mnext;
        logic [2:0] cand;
        int         pick;
        ing   = mb[m] && (mage[m] >= G);
        fwdm  = ing && stb[ms[m]];
        mdrop[m] = mdrop[m] | (stb & ~((ing ? 3'b001 : 3'b000) << ms[m]));
        mnext = mmask[m] & act;
        mcws[m] = 1'b0;
        if (!mb[m]) begin
            cand = act & ~mmask[m];
            pick = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m == 0) ? k : (mlast[m] + 1 + k) % N;
                if (pick < 0 && cand[j]) pick = j;
            end
            if (pick >= 0) begin
                mb[m] = 1'b1; ms[m] = pick; mlast[m] = pick; mage[m] = 0; mwc[m] = '0;
            end
        end else if (!ing) begin
            if (!act[ms[m]]) mb[m] = 1'b0;
            else begin
                mage[m] = mage[m] + 1;
                msil[m] = 0;
            end
        end else begin
            if (fwdm) begin
                mcws[m] = 1'b1;
                mcwd[m] = data[ms[m]*DW +: DW];
                if (mwc[m] != 16'hFFFF) mwc[m] = mwc[m] + 16'd1;
                msil[m] = 0;
            end else begin
                msil[m] = msil[m] + 1;
            end
            if (!act[ms[m]]) mb[m] = 1'b0;
            else if (msil[m] == TO) begin
                mtf[m] = 1'b1;
                mnext[ms[m]] = 1'b1;
                mb[m] = 1'b0;
            end
        end
        mmask[m] = mnext;
    endtask

    function automatic logic [56:0] model_out(input int m);
        return {mb[m], (mb[m] && mage[m] < G), (mb[m] ? 2'(ms[m]) : 2'd0), mcws[m],
                mcwd[m], mwc[m], mdrop[m], mtf[m]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        act = '0; stb = '0; data = '0;
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        model_init();
    endtask

    task automatic test_reset();
        do_reset();
        act = 3'b111; stb = 3'b111; data = {3{32'hA5A5A5A5}};
        tick(); tick();
        resetn = 1'b0;
        #1;
        total++;
        if (obs[0] !== 57'd0) begin bad++; $display("FAIL reset_async_fp: got %h want 0", obs[0]); end
        total++;
        if (obs[1] !== 57'd0) begin bad++; $display("FAIL reset_async_rr: got %h want 0", obs[1]); end
        tick();
        resetn = 1'b1;
        act = '0; stb = '0;
        total++;
        if (obs[0] !== 57'd0) begin bad++; $display("FAIL reset_release: got %h want 0", obs[0]); end
    endtask

    task automatic test_fixed();
        do_reset();
        act = 3'b110;
        tick();
        total++;
        if (ifa.ActiveSource !== 2'd1) begin bad++; $display("FAIL fp_grant: got %0d want 1", ifa.ActiveSource); end
        for (int i = 0; i < G; i++) begin
            total++;
            if (ifa.FSM_Reset !== 1'b1) begin bad++; $display("FAIL fp_guard_%0d: got %b want 1", i, ifa.FSM_Reset); end
            tick();
        end
        total++;
        if (ifa.FSM_Reset !== 1'b0 || ifa.ComActive !== 1'b1) begin
            bad++; $display("FAIL fp_granted: got rst=%b act=%b want 0 1", ifa.FSM_Reset, ifa.ComActive);
        end
        data[63:32] = 32'hDEADBEEF; stb = 3'b010;
        tick();
        stb = '0;
        total++;
        if (ifa.ConfigWriteStrobe !== 1'b1 || ifa.ConfigWriteData !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fp_forward: got %b/%h want 1/deadbeef", ifa.ConfigWriteStrobe, ifa.ConfigWriteData);
        end
        total++;
        if (ifa.WordCount !== 16'd1) begin bad++; $display("FAIL fp_wordcount: got %0d want 1", ifa.WordCount); end
        data[63:32] = 32'h0;
        tick();
        total++;
        if (ifa.ConfigWriteStrobe !== 1'b0 || ifa.ConfigWriteData !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fp_hold: got %b/%h want 0/deadbeef", ifa.ConfigWriteStrobe, ifa.ConfigWriteData);
        end
    endtask

    task automatic test_drop();
        do_reset();
        act = 3'b101;
        repeat (G + 1) tick();
        stb = 3'b100;
        tick();
        stb = '0;
        total++;
        if (ifa.ConfigWriteStrobe !== 1'b0) begin bad++; $display("FAIL drop_nofwd: got %b want 0", ifa.ConfigWriteStrobe); end
        total++;
        if (ifa.DroppedStrobe !== 3'b100) begin bad++; $display("FAIL drop_other: got %b want 100", ifa.DroppedStrobe); end
        total++;
        if (ifa.ComActive !== 1'b1 || ifa.ActiveSource !== 2'd0) begin
            bad++; $display("FAIL drop_keep_grant: got %b/%0d want 1/0", ifa.ComActive, ifa.ActiveSource);
        end
        do_reset();
        act = 3'b001;
        tick();
        stb = 3'b001;
        tick();
        stb = '0;
        total++;
        if (ifa.DroppedStrobe !== 3'b001 || ifa.ConfigWriteStrobe !== 1'b0) begin
            bad++; $display("FAIL drop_guard: got %b/%b want 001/0", ifa.DroppedStrobe, ifa.ConfigWriteStrobe);
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        do_reset();
        act = 3'b111;
        for (int s = 0; s < 4; s++) begin
            int n;
            int e;
            e = order[s];
            n = 0;
            while (!ifb.ComActive && n < 10) begin tick(); n++; end
            total++;
            if (ifb.ComActive !== 1'b1) begin bad++; $display("FAIL rr_wait_%0d: got %b want 1", s, ifb.ComActive); end
            total++;
            if (ifb.ActiveSource !== 2'(e)) begin bad++; $display("FAIL rr_order_%0d: got %0d want %0d", s, ifb.ActiveSource, e); end
            repeat (G) tick();
            stb = '0; stb[e] = 1'b1;
            tick(); tick();
            stb = '0;
            total++;
            if (ifb.WordCount !== 16'd2) begin bad++; $display("FAIL rr_words_%0d: got %0d want 2", s, ifb.WordCount); end
            act[e] = 1'b0;
            tick();
            act[e] = 1'b1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        act = 3'b001;
        repeat (G + 1) tick();
        repeat (TO - 1) tick();
        total++;
        if (ifa.ComActive !== 1'b1 || ifa.TimeoutFlag !== 1'b0) begin
            bad++; $display("FAIL to_early: got %b/%b want 1/0", ifa.ComActive, ifa.TimeoutFlag);
        end
        tick();
        total++;
        if (ifa.TimeoutFlag !== 1'b1 || ifa.ComActive !== 1'b0) begin
            bad++; $display("FAIL to_fire: got flag=%b act=%b want 1/0", ifa.TimeoutFlag, ifa.ComActive);
        end
        repeat (3) tick();
        total++;
        if (ifa.ComActive !== 1'b0) begin bad++; $display("FAIL to_masked: got %b want 0", ifa.ComActive); end
        act = 3'b000;
        tick();
        act = 3'b001;
        tick();
        total++;
        if (ifa.ComActive !== 1'b1 || ifa.TimeoutFlag !== 1'b1) begin
            bad++; $display("FAIL to_unmask: got act=%b flag=%b want 1/1", ifa.ComActive, ifa.TimeoutFlag);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        act = 3'b001;
        repeat (G + 1) tick();
        stb = 3'b001; data[31:0] = 32'h12345678;
        tick();
        total++;
        if (ifa.ConfigWriteStrobe !== 1'b1) begin bad++; $display("FAIL mid_pre: got %b want 1", ifa.ConfigWriteStrobe); end
        resetn = 1'b0;
        #1;
        total++;
        if (obs[0] !== 57'd0) begin bad++; $display("FAIL mid_async: got %h want 0", obs[0]); end
        tick();
        resetn = 1'b1;
        tick();
        total++;
        if (ifa.ConfigWriteStrobe !== 1'b0 || ifa.FSM_Reset !== 1'b1 || ifa.WordCount !== 16'd0) begin
            bad++; $display("FAIL mid_regrant: got stb=%b rst=%b wc=%0d want 0 1 0",
                            ifa.ConfigWriteStrobe, ifa.FSM_Reset, ifa.WordCount);
        end
        stb = '0;
        repeat (G) tick();
        total++;
        if (ifa.FSM_Reset !== 1'b0 || ifa.ComActive !== 1'b1) begin
            bad++; $display("FAIL mid_granted: got %b/%b want 0/1", ifa.FSM_Reset, ifa.ComActive);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        act = 3'b001;
        repeat (G + 1) tick();
        stb = 3'b001;
        for (int i = 1; i <= 70000; i++) begin
            data[31:0] = i;
            tick();
            if (i == 65534) begin
                total++;
                if (ifa.WordCount !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h want fffe", ifa.WordCount); end
            end
            if (i == 65535) begin
                total++;
                if (ifa.WordCount !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want ffff", ifa.WordCount); end
            end
        end
        total++;
        if (ifa.WordCount !== 16'hFFFF || ifa.ConfigWriteData !== 32'd70000) begin
            bad++; $display("FAIL sat_hold: got %h/%0d want ffff/70000", ifa.WordCount, ifa.ConfigWriteData);
        end
        stb = '0;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) act[i] = ~act[i];
                stb[i] = ($urandom_range(0, 3) == 0);
            end
            data = {$urandom, $urandom, $urandom};
            model_step(0);
            model_step(1);
            tick();
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs[m] !== model_out(m)) begin
                    bad++;
                    errs++;
                    if (errs < 10) $display("FAIL random_%0d cycle %0d: got %h want %h", m, c, obs[m], model_out(m));
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; act = '0; stb = '0; data = '0;
        model_init();
        test_reset();
        test_fixed();
        test_drop();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
